// File: rtl/tray_reader_if.sv
// Bundle between the puzzle/consumer and tray_reader: puzzle-side snapshot inputs,
// the ball stream and the run status outputs.
interface tray_reader_if #(
    parameter int TRAY_W = 32,
    parameter int SIZE_W = 5
);
    logic              stopped;
    logic [TRAY_W-1:0] tray;
    logic [SIZE_W-1:0] tray_size;

    // A ball moves on a rising clk edge where ball_valid & ball_ready are both 1. Once
    // ball_valid is raised, ball_colour/index/last hold until that edge, and ball_valid
    // never depends on ball_ready.
    logic              ball_valid;
    logic              ball_ready;
    logic              ball_colour;
    logic [SIZE_W-1:0] ball_index;
    logic              ball_last;

    logic              busy;
    logic              done;
    logic              match;

    modport master (
        input  stopped, tray, tray_size, ball_ready,
        output ball_valid, ball_colour, ball_index, ball_last, busy, done, match
    );

    modport slave (
        output stopped, tray, tray_size, ball_ready,
        input  ball_valid, ball_colour, ball_index, ball_last, busy, done, match
    );
endinterface

// File: rtl/tray_reader.sv
// Snapshots the puzzle tray when the run stops and streams the balls out, first-landed first.
// Optional TRAY_CHECK_EN adds a registered compare against EXPECT_TRAY/EXPECT_SIZE.
module tray_reader #(
    parameter int                TRAY_W      = 32,
    parameter int                SIZE_W      = 5,
    parameter logic [TRAY_W-1:0] EXPECT_TRAY = '0,
    parameter logic [SIZE_W-1:0] EXPECT_SIZE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    tray_reader_if.master bus,
    output logic [1:0]   dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              stopped_q;
    logic [TRAY_W-1:0] snap_q, snap_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [SIZE_W-1:0] idx_q, idx_d;
    logic              match_q, match_d;

    logic start;
    logic is_last;
    logic match_calc;

    assign start   = bus.stopped & ~stopped_q;
    assign is_last = (idx_q == size_q - SIZE_W'(1));

`ifdef TRAY_CHECK_EN
    logic [TRAY_W-1:0] cmp_tray;
    logic [SIZE_W-1:0] cmp_size;

    // An empty tray goes IDLE -> DONE without passing through the snapshot registers.
    assign cmp_tray = (state_q == IDLE) ? bus.tray      : snap_q;
    assign cmp_size = (state_q == IDLE) ? bus.tray_size : size_q;

    always_comb begin
        match_calc = (cmp_size == EXPECT_SIZE);
        for (int i = 0; i < TRAY_W; i++) begin
            if ((i < int'(cmp_size)) && (cmp_tray[i] != EXPECT_TRAY[i])) begin
                match_calc = 1'b0;
            end
        end
    end
`else
    logic unused_expect;
    assign unused_expect = ^{EXPECT_TRAY, EXPECT_SIZE};
    assign match_calc    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            stopped_q <= 1'b0;
            snap_q    <= '0;
            size_q    <= '0;
            idx_q     <= '0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            stopped_q <= bus.stopped;
            snap_q    <= snap_d;
            size_q    <= size_d;
            idx_q     <= idx_d;
            match_q   <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        size_d  = size_q;
        idx_d   = idx_q;
        match_d = match_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d = bus.tray;
                    size_d = bus.tray_size;
                    idx_d  = '0;
                    if (bus.tray_size != '0) begin
                        state_d = STREAM;
                        match_d = 1'b0;
                    end else begin
                        state_d = DONE;
                        match_d = match_calc;
                    end
                end
            end
            STREAM: begin
                if (bus.ball_ready) begin
                    if (is_last) begin
                        state_d = DONE;
                        match_d = match_calc;
                    end else begin
                        idx_d = idx_q + SIZE_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stream outputs are forced to zero outside STREAM so idle lines never carry stale data.
    assign bus.ball_valid  = (state_q == STREAM);
    assign bus.ball_colour = bus.ball_valid & snap_q[idx_q];
    assign bus.ball_index  = bus.ball_valid ? idx_q : '0;
    assign bus.ball_last   = bus.ball_valid & is_last;
    assign bus.busy        = (state_q == STREAM);
    assign bus.done        = (state_q == DONE);
    assign bus.match       = match_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_tray_reader.sv
// Self-checking bench for tray_reader: scenario tasks plus a scoreboard on the ball stream.
module tb_tray_reader;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int         n_checks;
    int         n_fail;
    logic [6:0] exp_q[$];
    logic [31:0] expect_tray_c;

    tray_reader_if #(.TRAY_W(32), .SIZE_W(5)) bif ();

    tray_reader #(
        .TRAY_W      (32),
        .SIZE_W      (5),
        .EXPECT_TRAY (32'b1011),
        .EXPECT_SIZE (5'd4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bif),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted ball is popped and compared as {colour, index, last}.
    always @(negedge clk) begin
        logic [6:0] got;
        logic [6:0] exp;
        got = {bif.ball_colour, bif.ball_index, bif.ball_last};
        if (rst_n && bif.ball_valid && bif.ball_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL stream_extra: got ball %h, expected no ball", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL stream_ball: got %h, expected %h", got, exp);
                end
            end
        end
        if (bif.ball_valid === 1'b0) begin
            n_checks++;
            if (got !== 7'd0) begin
                n_fail++;
                $display("FAIL idle_zero: got %h, expected 00", got);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input logic [31:0] t, input logic [4:0] s, input int count);
        for (int i = 0; i < count; i++) begin
            exp_q.push_back({t[i], 5'(i), (i == int'(s) - 1)});
        end
    endtask

    function automatic logic model_match(input logic [31:0] t, input logic [4:0] s);
        logic ok;
        ok = 1'b0;
`ifdef TRAY_CHECK_EN
        ok = (s == 5'd4);
        for (int i = 0; i < int'(s); i++) begin
            if (t[i] != expect_tray_c[i]) ok = 1'b0;
        end
`endif
        return ok;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bif.stopped = 1'b1;
        bif.tray = $urandom;
        bif.tray_size = 5'd5;
        bif.ball_ready = 1'b1;
        repeat (2) begin
            next_cycle();
            @(negedge clk);
            n_checks++;
            if ({bif.ball_valid, bif.ball_colour, bif.ball_index, bif.ball_last, bif.busy,
                 bif.done, bif.match, dbg_state} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got v=%b busy=%b done=%b st=%0d, expected all 0",
                         bif.ball_valid, bif.busy, bif.done, dbg_state);
            end
        end
        bif.stopped = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        repeat (2) begin
            next_cycle();
            @(negedge clk);
            n_checks++;
            if ({bif.ball_valid, bif.done, dbg_state} !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_idle: got v=%b done=%b st=%0d, expected idle",
                         bif.ball_valid, bif.done, dbg_state);
            end
        end
    endtask

    task automatic test_basic();
        bif.tray = 32'b1011;
        bif.tray_size = 5'd4;
        bif.ball_ready = 1'b1;
        push_expect(32'b1011, 5'd4, 4);
        bif.stopped = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            logic [2:0] exp_vbd;
            next_cycle();
            @(negedge clk);
            exp_vbd = (k <= 4) ? 3'b110 : (k == 5) ? 3'b001 : 3'b000;
            n_checks++;
            if ({bif.ball_valid, bif.busy, bif.done} !== exp_vbd) begin
                n_fail++;
                $display("FAIL basic_timing: cycle N+%0d got vbd=%b, expected %b", k,
                         {bif.ball_valid, bif.busy, bif.done}, exp_vbd);
            end
        end
        bif.stopped = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_drain: got %0d balls left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_backpressure();
        next_cycle();
        bif.tray = 32'b1011;
        bif.tray_size = 5'd4;
        push_expect(32'b1011, 5'd4, 4);
        bif.stopped = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            next_cycle();
            bif.ball_ready = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            n_checks++;
            if (bif.ball_valid !== (k <= 7)) begin
                n_fail++;
                $display("FAIL bp_valid: cycle N+%0d got %b, expected %b", k, bif.ball_valid, k <= 7);
            end
            if (k >= 2 && k <= 4) begin
                n_checks++;
                if ({bif.ball_colour, bif.ball_index, bif.ball_last} !== {1'b1, 5'd1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL bp_hold: cycle N+%0d got c=%b i=%0d l=%b, expected c=1 i=1 l=0",
                             k, bif.ball_colour, bif.ball_index, bif.ball_last);
                end
            end
            if (k >= 8) begin
                n_checks++;
                if (bif.done !== (k == 8)) begin
                    n_fail++;
                    $display("FAIL bp_done: cycle N+%0d got %b, expected %b", k, bif.done, k == 8);
                end
            end
        end
        bif.stopped = 1'b0;
        bif.ball_ready = 1'b1;
    endtask

    task automatic test_size_zero();
        next_cycle();
        bif.tray = $urandom;
        bif.tray_size = 5'd0;
        bif.stopped = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            logic [2:0] exp_vbd;
            next_cycle();
            @(negedge clk);
            exp_vbd = (k == 1) ? 3'b001 : 3'b000;
            n_checks++;
            if ({bif.ball_valid, bif.busy, bif.done} !== exp_vbd) begin
                n_fail++;
                $display("FAIL zero_size: cycle N+%0d got vbd=%b, expected %b", k,
                         {bif.ball_valid, bif.busy, bif.done}, exp_vbd);
            end
        end
        bif.stopped = 1'b0;
    endtask

    task automatic test_midstream();
        logic [31:0] t;
        next_cycle();
        t = $urandom;
        bif.tray = t;
        bif.tray_size = 5'd6;
        bif.ball_ready = 1'b1;
        push_expect(t, 5'd6, 2);
        bif.stopped = 1'b1;
        next_cycle();
        bif.tray = 32'd0;
        bif.stopped = 1'b0;
        @(negedge clk);
        next_cycle();
        bif.stopped = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bif.ball_index !== 5'd1) begin
            n_fail++;
            $display("FAIL mid_index: got %0d, expected 1", bif.ball_index);
        end
        next_cycle();
        bif.ball_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bif.ball_valid, bif.ball_colour, bif.ball_index} !== {1'b1, t[2], 5'd2}) begin
            n_fail++;
            $display("FAIL mid_snapshot: got v=%b c=%b i=%0d, expected v=1 c=%b i=2",
                     bif.ball_valid, bif.ball_colour, bif.ball_index, t[2]);
        end
        next_cycle();
        bif.stopped = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bif.ball_valid, bif.ball_index, bif.busy, bif.done, dbg_state} !== 10'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b i=%0d busy=%b done=%b st=%0d, expected all 0",
                     bif.ball_valid, bif.ball_index, bif.busy, bif.done, dbg_state);
        end
        next_cycle();
        rst_n = 1'b1;
        bif.ball_ready = 1'b1;
        repeat (3) begin
            next_cycle();
            @(negedge clk);
            n_checks++;
            if ({bif.ball_valid, bif.done} !== 2'b00) begin
                n_fail++;
                $display("FAIL mid_no_done: got v=%b done=%b, expected 0 0", bif.ball_valid, bif.done);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_drain: got %0d balls left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_match();
        logic [31:0] t_tab[3];
        logic [4:0]  s_tab[3];
        t_tab[0] = 32'hFFF0_000B; s_tab[0] = 5'd4;
        t_tab[1] = 32'b0011;      s_tab[1] = 5'd4;
        t_tab[2] = 32'b1011;      s_tab[2] = 5'd5;
        for (int c = 0; c < 3; c++) begin
            logic exp_m;
            logic seen;
            exp_m = model_match(t_tab[c], s_tab[c]);
            bif.tray = t_tab[c];
            bif.tray_size = s_tab[c];
            push_expect(t_tab[c], s_tab[c], int'(s_tab[c]));
            bif.stopped = 1'b1;
            seen = 1'b0;
            for (int k = 1; k <= 40 && !seen; k++) begin
                next_cycle();
                @(negedge clk);
                if (k == 1) begin
                    n_checks++;
                    if (bif.match !== 1'b0) begin
                        n_fail++;
                        $display("FAIL match_clear: case %0d got %b, expected 0", c, bif.match);
                    end
                end
                if (bif.done === 1'b1) seen = 1'b1;
            end
            bif.stopped = 1'b0;
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL match_timeout: case %0d got no done, expected done", c);
            end
            for (int h = 0; h < 3; h++) begin
                n_checks++;
                if (bif.match !== exp_m) begin
                    n_fail++;
                    $display("FAIL match_value: case %0d step %0d got %b, expected %b", c, h, bif.match, exp_m);
                end
                next_cycle();
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 8; r++) begin
            logic [31:0] t;
            logic [4:0]  s;
            logic        seen;
            logic        exp_m;
            s = (r == 0) ? 5'd31 : 5'($urandom_range(1, 31));
            t = $urandom;
            if (r == 0) t[31] = 1'b1;
            exp_m = model_match(t, s);
            bif.tray = t;
            bif.tray_size = s;
            push_expect(t, s, int'(s));
            bif.stopped = 1'b1;
            seen = 1'b0;
            for (int k = 0; k < 200 && !seen; k++) begin
                next_cycle();
                bif.ball_ready = 1'($urandom_range(0, 1));
                bif.tray = $urandom;
                @(negedge clk);
                if (bif.done === 1'b1) begin
                    seen = 1'b1;
                    n_checks++;
                    if (bif.match !== exp_m) begin
                        n_fail++;
                        $display("FAIL b2b_match: run %0d got %b, expected %b", r, bif.match, exp_m);
                    end
                end
            end
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL b2b_timeout: run %0d got no done within 200 cycles, expected done", r);
            end
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL b2b_drain: run %0d got %0d balls left, expected 0", r, exp_q.size());
                exp_q.delete();
            end
            bif.stopped = 1'b0;
            bif.ball_ready = 1'b1;
            next_cycle();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        expect_tray_c = 32'b1011;
        test_reset();
        test_basic();
        test_backpressure();
        test_size_zero();
        test_midstream();
        test_match();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
